// File: rtl/uart_spi_pkg.sv
// Shared types and default sizing for the UART/SPI loopback bridge controller.
package uart_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    XFER,
    RELEASE,
    DRAIN
  } bridge_state_t;

  localparam int BRIDGE_MAX_LEN    = 16;
  localparam int BRIDGE_FIFO_DEPTH = 4;
  localparam int BRIDGE_TIMEOUT    = 100000;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with a combinational head; simultaneous push and pop keep the count.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_spi_bridge_ctrl.sv
// Frame parser and sequencer: length-prefixed UART frames become SPI transfers
// under one chip-select window, and MISO bytes are returned over the UART.
module uart_spi_bridge_ctrl
  import uart_spi_pkg::*;
#(
  parameter int MAX_LEN        = BRIDGE_MAX_LEN,
  parameter int FIFO_DEPTH     = BRIDGE_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = BRIDGE_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] freq_control,
  input  logic [7:0] uart_rx_byte,
  input  logic       uart_rx_valid,
  output logic [7:0] uart_tx_byte,
  output logic       uart_tx_start,
  input  logic       uart_tx_ready,
  output logic [7:0] spi_tx_byte,
  output logic       spi_start,
  input  logic [7:0] spi_rx_byte,
  input  logic       spi_rx_valid,
  input  logic       spi_tx_done,
  output logic       cs_bar,
  output logic [1:0] spi_freq_sel,
  output logic       busy,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  bridge_state_t state;
  logic [7:0]    remaining;
  logic [7:0]    hold_byte;
  logic          hold_valid;
  logic          rx_seen;
  logic          done_seen;
  logic [7:0]    rx_latched;
  logic          abort_pending;
  logic [TW-1:0] tmo_cnt;

  logic       fifo_push;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] push_data;
  logic       xfer_done;
  logic       issue;
  logic       capture;
  logic       overrun;
  logic       timeout;

  // MISO byte and done pulse may arrive in either order, so sticky flags cover the gap.
  assign xfer_done = (state == XFER) && (rx_seen || spi_rx_valid) && (done_seen || spi_tx_done);
  assign push_data = spi_rx_valid ? spi_rx_byte : rx_latched;
  assign fifo_push = xfer_done;
  assign issue     = (state == PAYLOAD) && hold_valid && !fifo_full;
  assign capture   = uart_rx_valid && !abort_pending && ((state == PAYLOAD) || (state == XFER));
  assign overrun   = capture && hold_valid && !issue;
  assign timeout   = (state == PAYLOAD) && !hold_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign fifo_pop  = !fifo_empty && uart_tx_ready && !uart_tx_start;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame sequencer; abort paths are written last so they override normal progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      hold_byte     <= '0;
      hold_valid    <= 1'b0;
      rx_seen       <= 1'b0;
      done_seen     <= 1'b0;
      rx_latched    <= '0;
      abort_pending <= 1'b0;
      tmo_cnt       <= '0;
      cs_bar        <= 1'b1;
      spi_freq_sel  <= 2'b00;
      spi_start     <= 1'b0;
      spi_tx_byte   <= '0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (uart_rx_valid) begin
            if (uart_rx_byte == 8'd0 || uart_rx_byte > 8'(MAX_LEN)) begin
              frame_err <= 1'b1;
            end else begin
              remaining     <= uart_rx_byte;
              spi_freq_sel  <= freq_control;
              hold_valid    <= 1'b0;
              rx_seen       <= 1'b0;
              done_seen     <= 1'b0;
              abort_pending <= 1'b0;
              tmo_cnt       <= '0;
              busy          <= 1'b1;
              state         <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (capture) begin
            hold_byte  <= uart_rx_byte;
            hold_valid <= 1'b1;
            cs_bar     <= 1'b0;
          end
          if (issue) begin
            spi_tx_byte <= hold_byte;
            spi_start   <= 1'b1;
            tmo_cnt     <= '0;
            rx_seen     <= 1'b0;
            done_seen   <= 1'b0;
            if (!capture) hold_valid <= 1'b0;
            state <= XFER;
          end else if (!hold_valid) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          if (overrun || timeout) begin
            frame_err  <= 1'b1;
            hold_valid <= 1'b0;
            cs_bar     <= 1'b1;
            state      <= DRAIN;
          end
        end
        XFER: begin
          if (spi_rx_valid) begin
            rx_seen    <= 1'b1;
            rx_latched <= spi_rx_byte;
          end
          if (spi_tx_done) done_seen <= 1'b1;
          if (capture) begin
            hold_byte  <= uart_rx_byte;
            hold_valid <= 1'b1;
          end
          if (overrun) begin
            frame_err     <= 1'b1;
            hold_valid    <= 1'b0;
            abort_pending <= 1'b1;
          end
          if (xfer_done) begin
            rx_seen   <= 1'b0;
            done_seen <= 1'b0;
            remaining <= remaining - 1'b1;
            if (abort_pending || overrun) begin
              abort_pending <= 1'b0;
              cs_bar        <= 1'b1;
              state         <= DRAIN;
            end else if (remaining == 8'd1) begin
              state <= RELEASE;
            end else begin
              tmo_cnt <= '0;
              state   <= PAYLOAD;
            end
          end
        end
        RELEASE: begin
          cs_bar <= 1'b1;
          state  <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path: one pop per request, with a guaranteed low cycle between start pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_tx_start <= 1'b0;
      uart_tx_byte  <= '0;
    end else begin
      uart_tx_start <= fifo_pop;
      if (fifo_pop) uart_tx_byte <= fifo_head;
    end
  end

endmodule

// File: tb/tb_uart_spi_bridge_ctrl.sv
// Scoreboard bench for uart_spi_bridge_ctrl with a behavioural SPI responder and UART sink.
module tb_uart_spi_bridge_ctrl;

  localparam int TMO = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] freq_control;
  logic [7:0] uart_rx_byte;
  logic       uart_rx_valid;
  logic [7:0] uart_tx_byte;
  logic       uart_tx_start;
  logic       uart_tx_ready;
  logic [7:0] spi_tx_byte;
  logic       spi_start;
  logic [7:0] spi_rx_byte;
  logic       spi_rx_valid;
  logic       spi_tx_done;
  logic       cs_bar;
  logic [1:0] spi_freq_sel;
  logic       busy;
  logic       frame_err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int spi_lat = 2;
  int spi_start_count = 0;
  int uart_tx_count = 0;
  int err_count = 0;
  int err_cyc = 0;
  int last_start_cyc = 0;
  int cs_rise_count = 0;
  logic cs_prev = 1'b1;

  logic [7:0] exp_mosi [$];
  logic [7:0] exp_tx [$];
  logic [7:0] miso_q [$];

  uart_spi_bridge_ctrl #(.MAX_LEN(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .freq_control  (freq_control),
    .uart_rx_byte  (uart_rx_byte),
    .uart_rx_valid (uart_rx_valid),
    .uart_tx_byte  (uart_tx_byte),
    .uart_tx_start (uart_tx_start),
    .uart_tx_ready (uart_tx_ready),
    .spi_tx_byte   (spi_tx_byte),
    .spi_start     (spi_start),
    .spi_rx_byte   (spi_rx_byte),
    .spi_rx_valid  (spi_rx_valid),
    .spi_tx_done   (spi_tx_done),
    .cs_bar        (cs_bar),
    .spi_freq_sel  (spi_freq_sel),
    .busy          (busy),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    @(negedge clk);
    uart_rx_byte  = b;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    check_output("busy_fall", busy, 0);
  endtask

  // SPI responder: cycles through MISO-first, simultaneous and done-first completions.
  initial begin
    int order;
    logic [7:0] b;
    order = 0;
    spi_rx_valid = 1'b0;
    spi_tx_done  = 1'b0;
    spi_rx_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        repeat (spi_lat) @(negedge clk);
        b = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hEE;
        spi_rx_byte = b;
        case (order)
          0: begin
            spi_rx_valid = 1'b1; @(negedge clk); spi_rx_valid = 1'b0;
            spi_tx_done  = 1'b1; @(negedge clk); spi_tx_done  = 1'b0;
          end
          1: begin
            spi_rx_valid = 1'b1; spi_tx_done = 1'b1; @(negedge clk);
            spi_rx_valid = 1'b0; spi_tx_done = 1'b0;
          end
          default: begin
            spi_tx_done  = 1'b1; @(negedge clk); spi_tx_done  = 1'b0;
            spi_rx_valid = 1'b1; @(negedge clk); spi_rx_valid = 1'b0;
          end
        endcase
        order = (order + 1) % 3;
      end
    end
  end

  // Output monitor: pops the scoreboards whenever the DUT issues a transfer or transmit.
  always @(negedge clk) begin
    if (spi_start) begin
      spi_start_count++;
      last_start_cyc = cyc;
      if (exp_mosi.size() > 0) check_output("mosi_byte", spi_tx_byte, exp_mosi.pop_front());
      else check_output("mosi_unexpected_start", 1, 0);
      check_output("cs_low_at_start", cs_bar, 0);
    end
    if (uart_tx_start) begin
      uart_tx_count++;
      if (exp_tx.size() > 0) check_output("uart_tx_byte", uart_tx_byte, exp_tx.pop_front());
      else check_output("uart_tx_unexpected", 1, 0);
    end
    if (frame_err) begin
      err_count++;
      err_cyc = cyc;
    end
    if (cs_bar && !cs_prev) cs_rise_count++;
    cs_prev = cs_bar;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_start;
    int base_tx;
    int base_err;
    int elapsed;
    reset         = 1'b1;
    freq_control  = 2'b00;
    uart_rx_byte  = 8'h00;
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_cs_bar", cs_bar, 1);
    check_output("reset_strobes", {spi_start, uart_tx_start, busy, frame_err}, 4'b0000);
    check_output("reset_freq_sel", spi_freq_sel, 0);
    check_output("reset_bytes", {uart_tx_byte, spi_tx_byte}, 16'h0000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] two-byte frame");
    freq_control = 2'b10;
    miso_q.push_back(8'h11); miso_q.push_back(8'h22);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    exp_mosi.push_back(8'hA5); exp_mosi.push_back(8'h3C);
    apply_stimulus(8'h02, 0);
    check_output("busy_after_len", busy, 1);
    check_output("freq_latched", spi_freq_sel, 2'b10);
    check_output("cs_high_after_len", cs_bar, 1);
    apply_stimulus(8'hA5, 0);
    check_output("cs_fall_first_byte", cs_bar, 0);
    check_output("start_not_early", spi_start, 0);
    @(negedge clk);
    check_output("start_latency", spi_start, 1);
    freq_control = 2'b01;
    repeat (30) @(negedge clk);
    check_output("freq_hold_midframe", spi_freq_sel, 2'b10);
    apply_stimulus(8'h3C, 30);
    wait_idle(200);
    check_output("frame1_starts", spi_start_count, 2);
    check_output("frame1_tx_count", uart_tx_count, 2);
    check_output("frame1_cs_single_window", cs_rise_count, 1);
    check_output("frame1_cs_end", cs_bar, 1);
    check_output("freq_hold_after_frame", spi_freq_sel, 2'b10);

    $display("[TB] bad lengths");
    apply_stimulus(8'h00, 0);
    check_output("err_len0", frame_err, 1);
    @(negedge clk);
    check_output("err_len0_pulse", frame_err, 0);
    apply_stimulus(8'h11, 0);
    check_output("err_len17", frame_err, 1);
    repeat (5) @(negedge clk);
    check_output("err_count", err_count, 2);
    check_output("err_no_starts", spi_start_count, 2);
    check_output("err_cs_high", cs_bar, 1);
    check_output("err_not_busy", busy, 0);

    $display("[TB] new rate on next frame");
    miso_q.push_back(8'h77); exp_tx.push_back(8'h77); exp_mosi.push_back(8'h5A);
    apply_stimulus(8'h01, 0);
    check_output("freq_next_frame", spi_freq_sel, 2'b01);
    apply_stimulus(8'h5A, 30);
    wait_idle(200);

    $display("[TB] fifo backpressure");
    uart_tx_ready = 1'b0;
    base_start = spi_start_count;
    base_tx = uart_tx_count;
    for (int i = 0; i < 6; i++) begin
      miso_q.push_back(8'hC0 + 8'(i));
      exp_tx.push_back(8'hC0 + 8'(i));
      exp_mosi.push_back(8'h40 + 8'(i));
    end
    apply_stimulus(8'h06, 30);
    for (int i = 0; i < 5; i++) apply_stimulus(8'h40 + 8'(i), 30);
    repeat (40) @(negedge clk);
    check_output("fifo_full_stall", spi_start_count - base_start, 4);
    check_output("fifo_full_no_tx", uart_tx_count - base_tx, 0);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 100 && (spi_start_count - base_start) < 5; i++) @(negedge clk);
    check_output("fifo_resume", spi_start_count - base_start, 5);
    apply_stimulus(8'h45, 30);
    wait_idle(300);
    check_output("fifo_all_returned", uart_tx_count - base_tx, 6);

    $display("[TB] inter-byte timeout");
    base_err = err_count;
    base_tx = uart_tx_count;
    miso_q.push_back(8'h99); exp_tx.push_back(8'h99); exp_mosi.push_back(8'h81);
    apply_stimulus(8'h03, 0);
    apply_stimulus(8'h81, 0);
    for (int i = 0; i < 2 * TMO && err_count == base_err; i++) @(negedge clk);
    check_output("timeout_err_pulse", err_count - base_err, 1);
    elapsed = err_cyc - last_start_cyc;
    check_output("timeout_window", (elapsed >= TMO && elapsed <= TMO + 30) ? 1 : 0, 1);
    @(negedge clk);
    check_output("timeout_cs_high", cs_bar, 1);
    wait_idle(100);
    check_output("timeout_byte_returned", uart_tx_count - base_tx, 1);

    $display("[TB] reset during transfer");
    uart_tx_ready = 1'b0;
    spi_lat = 15;
    base_start = spi_start_count;
    base_tx = uart_tx_count;
    miso_q.push_back(8'hD1); miso_q.push_back(8'hD2);
    exp_mosi.push_back(8'h61); exp_mosi.push_back(8'h62);
    apply_stimulus(8'h04, 30);
    apply_stimulus(8'h61, 40);
    apply_stimulus(8'h62, 0);
    for (int i = 0; i < 10 && (spi_start_count - base_start) < 2; i++) @(negedge clk);
    check_output("reset_test_second_start", spi_start_count - base_start, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("midreset_cs_high", cs_bar, 1);
    check_output("midreset_not_busy", busy, 0);
    uart_tx_ready = 1'b1;
    repeat (60) @(negedge clk);
    check_output("midreset_no_starts", spi_start_count - base_start, 2);
    check_output("midreset_fifo_empty", uart_tx_count - base_tx, 0);

    check_output("mosi_queue_empty", exp_mosi.size(), 0);
    check_output("tx_queue_empty", exp_tx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_spi_bridge_ctrl.md
# uart_spi_bridge_ctrl

Byte-level controller that sequences the UART and SPI blocks of the UART/SPI loopback top. It parses length-prefixed frames arriving on the UART receiver and issues one SPI transfer per payload byte under a single chip-select window. Every byte returned on MISO goes into a small FIFO and is sent back through the UART transmitter. It also latches the SPI clock-rate select per frame, so the rate cannot change mid-transfer.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255).
- `FIFO_DEPTH`, 4: return-byte FIFO depth (power of 2, ≥2).
- `TIMEOUT_CYCLES`, 100000: maximum clk cycles between payload bytes before abort.

Ports:
- `clk`  in  1  system clock; everything runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `freq_control`  in  2  requested SPI rate, sampled at frame start.
- `uart_rx_byte`  in  8  received UART byte, valid with `uart_rx_valid`.
- `uart_rx_valid`  in  1  one-cycle pulse per received byte; cannot be stalled.
- `uart_tx_byte`  out  8  byte to transmit, valid with `uart_tx_start`.
- `uart_tx_start`  out  1  one-cycle transmit request.
- `uart_tx_ready`  in  1  UART transmitter idle.
- `spi_tx_byte`  out  8  MOSI byte, valid with `spi_start`.
- `spi_start`  out  1  one-cycle SPI transfer request.
- `spi_rx_byte`  in  8  MISO byte, valid with `spi_rx_valid`.
- `spi_rx_valid`  in  1  one-cycle pulse, MISO byte captured.
- `spi_tx_done`  in  1  one-cycle pulse, transfer finished.
- `cs_bar`  out  1  chip select, active low.
- `spi_freq_sel`  out  2  latched rate select to the SPI block.
- `busy`  out  1  high in any state other than IDLE.
- `frame_err`  out  1  one-cycle pulse on protocol error.

## Operation
- Frame format: byte 0 is the length N; bytes 1..N are the payload.
- FSM states: IDLE, PAYLOAD, XFER, RELEASE, DRAIN.
- IDLE: on `uart_rx_valid`:
  - N=0 or N>`MAX_LEN` → pulse `frame_err`, stay in IDLE.
  - Otherwise load `remaining`=N, latch `spi_freq_sel`←`freq_control`, go to PAYLOAD.
- Hold register: one byte plus `hold_valid`. It captures every `uart_rx_valid` byte while in PAYLOAD or XFER.
  - A capture while `hold_valid`=1 is an overrun → abort.
- PAYLOAD: when `hold_valid`=1 and the FIFO is not full:
  - drive `spi_tx_byte`←hold, pulse `spi_start`, clear `hold_valid`, go to XFER.
  - If the FIFO is full, wait; UART bytes continue into the hold register.
- XFER: wait until both `spi_rx_valid` and `spi_tx_done` have been seen. They may arrive in either order or in the same cycle; use sticky flags.
  - Push `spi_rx_byte` into the FIFO, decrement `remaining`.
  - `remaining`=0 → RELEASE; otherwise → PAYLOAD.
- RELEASE: `cs_bar`←1, then go to DRAIN.
- DRAIN: go to IDLE when the FIFO is empty.
- Abort (overrun, or `TIMEOUT_CYCLES` elapsed in PAYLOAD with `hold_valid`=0):
  - pulse `frame_err`, clear the hold register;
  - if in XFER, let the current transfer finish and push its byte;
  - then `cs_bar`←1 and go to DRAIN. FIFO contents are still transmitted.
- Return path runs in parallel with the FSM:
  - when the FIFO is non-empty, `uart_tx_ready`=1 and `uart_tx_start` was low last cycle: pop the head to `uart_tx_byte`, pulse `uart_tx_start`.
- FIFO push and pop in the same cycle are both honored, with count unchanged.
- `uart_rx_valid` in RELEASE or DRAIN is ignored.

## Timing
- Reset values:
  - `cs_bar`=1, `spi_freq_sel`=0;
  - `spi_start`=0, `uart_tx_start`=0, `busy`=0, `frame_err`=0;
  - `uart_tx_byte`=0, `spi_tx_byte`=0.
- Reset state: FIFO empty, `hold_valid`=0, FSM in IDLE, timeout counter cleared.
- Reset mid-frame: all of the above on the next edge. No further `spi_start` or `uart_tx_start` is issued.
- All outputs are registered.
- Length byte `uart_rx_valid` at cycle t → `busy`=1 and `spi_freq_sel` updated at t+1.
- Payload byte `uart_rx_valid` at t (FIFO not full, in PAYLOAD) → `hold_valid` at t+1 → `spi_start` at t+2.
  - First byte only: `cs_bar` falls at t+1.
- Last byte's completion (later of `spi_rx_valid`/`spi_tx_done`) at t → RELEASE at t+1, `cs_bar`=1 at t+2.
- FIFO push at t → earliest `uart_tx_start` at t+2.
- Consecutive `uart_tx_start` pulses are separated by at least one low cycle.
- Timeout counter resets on every `spi_start` and on entry to PAYLOAD. Abort fires on the cycle the counter reaches `TIMEOUT_CYCLES`.

## Structure
- Package `uart_spi_pkg` holds:
  - the state enum `bridge_state_t`;
  - default constants `BRIDGE_MAX_LEN`, `BRIDGE_FIFO_DEPTH`, `BRIDGE_TIMEOUT`.
- Sub-module `byte_fifo`: synchronous FIFO with `push`, `pop`, `full`, `empty`, head data out.
  - Parameterized by depth; pointers wrap modulo `FIFO_DEPTH`.
- The FSM, hold register, timeout counter and TX pop logic live in `uart_spi_bridge_ctrl`.

## Test plan
- Frame {0x02, 0xA5, 0x3C}, SPI model returns 0x11, 0x22:
  - two `spi_start` pulses with bytes 0xA5, 0x3C;
  - `cs_bar` low continuously across both;
  - UART TX sends 0x11 then 0x22;
  - `busy` falls after the FIFO drains.
- Length 0x00, then length 0x11 with `MAX_LEN`=16 → each pulses `frame_err` once, no `spi_start`, `cs_bar` stays 1.
- `freq_control`=2'b10 at the length byte, changed to 2'b01 mid-frame → `spi_freq_sel` holds 2'b10 until the next frame.
- `uart_tx_ready` held low, 6-byte frame, `FIFO_DEPTH`=4:
  - after 4 transfers `spi_start` stalls;
  - releasing `uart_tx_ready` resumes transfers;
  - all 6 bytes are returned in order.
- Length 3, one payload byte, then silence for `TIMEOUT_CYCLES`:
  - `frame_err` pulse, `cs_bar`=1;
  - the single returned byte is still transmitted;
  - FSM ends in IDLE.
- `reset` asserted during XFER of byte 2 of 4 → next cycle `cs_bar`=1, `busy`=0, FIFO empty, no further starts.
